// File: rtl/audio_pwm_pkg.sv
// rtl/audio_pwm_pkg.sv - shared types, constants and saturation helper for the audio PWM output stage
package audio_pwm_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    localparam logic [7:0]  MIDSCALE   = 8'd128;
    localparam logic [8:0]  GAIN_UNITY = 9'd256;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    function automatic logic [7:0] sat_u8(input logic signed [17:0] v);
        logic [7:0] r;
        if (v < 18'sd0) begin
            r = 8'd0;
        end else if (v > 18'sd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_pwm_out_volume_ramp.sv
// rtl/audio_pwm_out_volume_ramp.sv - mute/unmute gain ramp FSM, gain stepped only on sample ticks
module volume_ramp
    import audio_pwm_pkg::*;
#(
    parameter int RAMP_STEP = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       mute_i,
    output logic [8:0] gain,
    output logic       muted
);

    localparam logic [9:0] STEP = 10'(RAMP_STEP);

    ramp_state_t state_q, state_d;
    logic [8:0]  gain_q, gain_d;
    logic [9:0]  up_sum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= MUTED;
            gain_q  <= 9'd0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // A mute change never blocks the step of the current state on a coincident tick.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        up_sum  = {1'b0, gain_q} + STEP;
        case (state_q)
            MUTED: begin
                gain_d = 9'd0;
                if (!mute_i) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (tick) begin
                    gain_d = (up_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : up_sum[8:0];
                end
                if (mute_i) begin
                    state_d = RAMP_DOWN;
                end else if (tick && (up_sum >= {1'b0, GAIN_UNITY})) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                gain_d = GAIN_UNITY;
                if (mute_i) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (tick) begin
                    gain_d = ({1'b0, gain_q} <= STEP) ? 9'd0 : (gain_q - STEP[8:0]);
                end
                if (!mute_i) begin
                    state_d = RAMP_UP;
                end else if (tick && ({1'b0, gain_q} <= STEP)) begin
                    state_d = MUTED;
                end
            end
            default: begin
                state_d = MUTED;
                gain_d  = 9'd0;
            end
        endcase
    end

    always_comb begin
        muted = (state_q == MUTED);
        gain  = gain_q;
    end

endmodule

// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - 48 kHz sample capture, gain scaling and 8-bit PWM pin driver
// Optional AUDIO_PWM_DITHER_EN adds a per-tick LFSR LSB dither before saturation.
module audio_pwm_out
    import audio_pwm_pkg::*;
#(
    parameter int CLK_DIV   = 260,
    parameter int RAMP_STEP = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] sample_data_i,
    input  logic       mute_i,
    output logic       sample_tick_o,
    output logic [8:0] gain_o,
    output logic       muted_o,
    output logic       pwm_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [7:0]         sample_q, sample_d;
    logic               scale_pend_q, scale_pend_d;
    logic [7:0]         duty_next_q, duty_next_d;
    logic [7:0]         duty_active_q, duty_active_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic               pwm_q, pwm_d;
    logic               tick;
    logic               dith;
    logic [8:0]         gain;
    logic               muted;
    logic signed [8:0]  s;
    logic signed [17:0] p;
    logic signed [17:0] y;

    volume_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp (
        .clk    (clk),
        .rstn   (rstn),
        .tick   (tick),
        .mute_i (mute_i),
        .gain   (gain),
        .muted  (muted)
    );

`ifdef AUDIO_PWM_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (tick) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        dith = lfsr_q[0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`else
    always_comb dith = 1'b0;
`endif

    always_comb begin
        tick         = (div_cnt_q == DIV_LAST);
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        sample_d     = tick ? sample_data_i : sample_q;
        scale_pend_d = tick;
    end

    // Scaling runs the cycle after the tick so it sees the freshly captured sample and stepped gain.
    always_comb begin
        s           = $signed({1'b0, sample_q}) - $signed({1'b0, MIDSCALE});
        p           = s * $signed({1'b0, gain});
        y           = (p >>> 8) + 18'sd128 + $signed({17'd0, dith});
        duty_next_d = scale_pend_q ? sat_u8(y) : duty_next_q;
    end

    // Duty is only swapped at the wrap so a carrier period is never torn.
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + 8'd1;
        duty_active_d = (pwm_cnt_q == 8'hFF) ? duty_next_q : duty_active_q;
        pwm_d         = (pwm_cnt_q < duty_active_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q     <= '0;
            sample_q      <= MIDSCALE;
            scale_pend_q  <= 1'b0;
            duty_next_q   <= MIDSCALE;
            duty_active_q <= MIDSCALE;
            pwm_cnt_q     <= 8'd0;
            pwm_q         <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            sample_q      <= sample_d;
            scale_pend_q  <= scale_pend_d;
            duty_next_q   <= duty_next_d;
            duty_active_q <= duty_active_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pwm_q         <= pwm_d;
        end
    end

    always_comb begin
        sample_tick_o = tick;
        gain_o        = gain;
        muted_o       = muted;
        pwm_o         = pwm_q;
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb/tb_audio_pwm_out.sv - self-checking bench: per-cycle behavioural model plus directed scenarios
module tb_audio_pwm_out;

    localparam int CD = 100;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] sample_data_i;
    logic       mute_i;
    logic       sample_tick_o;
    logic [8:0] gain_o;
    logic       muted_o;
    logic       pwm_o;

    int checks = 0;
    int errors = 0;

    audio_pwm_out #(.CLK_DIV(CD), .RAMP_STEP(1)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .sample_data_i (sample_data_i),
        .mute_i        (mute_i),
        .sample_tick_o (sample_tick_o),
        .gain_o        (gain_o),
        .muted_o       (muted_o),
        .pwm_o         (pwm_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int model_duty(input int smp, input int g);
        int p, y;
        p = (smp - 128) * g;
        if (p >= 0) y = p / 256;
        else        y = -((-p + 255) / 256);
        y = y + 128;
        if (y < 0)   y = 0;
        if (y > 255) y = 255;
        return y;
    endfunction

    // Model state: cycles since reset release, gain, ramp direction, sample and duty pipeline.
    int m_cyc, m_pc, m_gain, m_sample, m_dn, m_da;
    bit m_up, m_pend, m_pwm, m_tick_now;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cyc = 0; m_pc = 0; m_gain = 0; m_up = 0; m_sample = 128;
            m_dn = 128; m_da = 128; m_pwm = 0; m_pend = 0;
        end else begin
            m_tick_now = (m_cyc % CD) == CD - 1;
            m_pwm = (m_pc < m_da);
            if (m_pc == 255) m_da = m_dn;
            if (m_pend) m_dn = model_duty(m_sample, m_gain);
            m_pend = m_tick_now;
            if (m_tick_now) begin
                m_sample = int'(sample_data_i);
                if (m_up) m_gain = (m_gain + 1 > 256) ? 256 : m_gain + 1;
                else      m_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
            end
            m_up  = !mute_i;
            m_cyc = m_cyc + 1;
            m_pc  = (m_pc + 1) % 256;
        end
    end

    always @(negedge clk) begin
        check("cyc_tick",  int'(sample_tick_o), int'(rstn && ((m_cyc % CD) == CD - 1)));
        check("cyc_gain",  int'(gain_o), m_gain);
        check("cyc_muted", int'(muted_o), int'(m_gain == 0 && !m_up));
        check("cyc_pwm",   int'(pwm_o), int'(m_pwm));
    end

    task automatic count_high(output int n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_o) n++;
        end
    endtask

    task automatic wait_tick(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2 * CD; i++) begin
            @(negedge clk);
            if (sample_tick_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check(name, 0, 1);
    endtask

    task automatic ticks_to_gain(input int target, output int n);
        bit ok;
        ok = 0;
        n  = 0;
        for (int i = 0; i < 300 * CD; i++) begin
            @(negedge clk);
            if (int'(gain_o) == target) begin
                ok = 1;
                break;
            end
            if (sample_tick_o) n++;
        end
        if (!ok) n = -1;
    endtask

    int n;

    initial begin
        rstn = 1'b0;
        mute_i = 1'b1;
        sample_data_i = 8'hFF;

        check("pin_ff_unity", model_duty(255, 256), 255);
        check("pin_00_unity", model_duty(0, 256), 0);
        check("pin_80_unity", model_duty(128, 256), 128);
        check("pin_ff_zero",  model_duty(255, 0), 128);
        check("pin_00_half",  model_duty(0, 128), 64);
        check("pin_7f_half",  model_duty(127, 128), 127);

        repeat (3) @(negedge clk);
        check("rst_gain",  int'(gain_o), 0);
        check("rst_muted", int'(muted_o), 1);
        check("rst_pwm",   int'(pwm_o), 0);
        check("rst_tick",  int'(sample_tick_o), 0);

        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * CD; i++) begin
            @(negedge clk);
            n++;
            if (sample_tick_o) break;
        end
        check("first_tick_delay", n, CD - 1);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            for (int i = 0; i < 2 * CD; i++) begin
                @(negedge clk);
                n++;
                if (sample_tick_o) break;
            end
            check("tick_spacing", n, CD);
        end

        repeat (10) @(negedge clk);
        count_high(n);
        check("muted_ff_high", n, 128);
        check("muted_gain", int'(gain_o), 0);

        wait_tick("t5_align_to");
        @(negedge clk);
        mute_i = 1'b0;
        ticks_to_gain(100, n);
        check("up_to_100_ticks", n, 100);
        check("up_not_muted", int'(muted_o), 0);
        mute_i = 1'b1;
        ticks_to_gain(0, n);
        check("down_from_100_ticks", n, 100);
        check("down_muted", int'(muted_o), 1);

        wait_tick("t3_align_to");
        @(negedge clk);
        mute_i = 1'b0;
        ticks_to_gain(256, n);
        check("up_to_256_ticks", n, 256);
        check("play_not_muted", int'(muted_o), 0);
        repeat (2 * 256 + CD + 4) @(negedge clk);
        count_high(n);
        check("play_ff_high", n, 255);

        sample_data_i = 8'h00;
        repeat (2 * 256 + CD + 4) @(negedge clk);
        count_high(n);
        check("play_00_high", n, 0);

        sample_data_i = 8'h80;
        repeat (2 * 256 + CD + 4) @(negedge clk);
        count_high(n);
        check("play_80_high", n, 128);

        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_gain",  int'(gain_o), 0);
        check("async_rst_muted", int'(muted_o), 1);
        check("async_rst_pwm",   int'(pwm_o), 0);
        check("async_rst_tick",  int'(sample_tick_o), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_gain", int'(gain_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
